// File: rtl/pkt_rx_len_tracker_pkg.sv
// Shared types and constants for the UDP RX packet-length tracker.
// Holds the AXI-Stream byte channel structs, the UDP length type and the
// tracker FSM state encoding.
package pkt_rx_len_tracker_pkg;

    localparam int INFIFO_KB_SIZE = 4;
    localparam int RX_LEN_SLOTS   = 4;

    typedef logic [15:0] udp_length_t;

    typedef struct packed {
        logic [7:0] tdata;
        logic       tvalid;
        logic       tlast;
    } s_axis_mosi_t;

    typedef struct packed {
        logic tready;
    } s_axis_miso_t;

    typedef enum logic [1:0] {
        IDLE_RXL_ST,
        PKT_RXL_ST,
        DROP_RXL_ST
    } fsm_rx_len_t;

endpackage

// File: rtl/pkt_rx_len_tracker_eth_fifo.sv
// Small first-word-fall-through FIFO used as the packet-length queue.
// SLOTS must be a power of two; occupancy MSB doubles as the full flag.
module pkt_rx_len_tracker_eth_fifo #(
    parameter int SLOTS = 4,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         din_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     valid_o,
    output logic                     full_o,
    output logic [$clog2(SLOTS):0]   ocup_o
);

    localparam int AW = $clog2(SLOTS);

    logic [WIDTH-1:0] mem_q [SLOTS];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      ocup_q;
    logic             push_en, pop_en;

    assign valid_o = (ocup_q != '0);
    assign full_o  = ocup_q[AW];
    assign ocup_o  = ocup_q;
    assign dout_o  = valid_o ? mem_q[rd_ptr_q] : '0;

    // Pops on an empty queue and pushes into a full one are ignored.
    assign pop_en  = pop_i & valid_o;
    assign push_en = push_i & ~full_o;

    // Storage array, written only; no reset needed for the payload.
    always_ff @(posedge clk) begin
        if (push_en && !clear_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    // Pointers and occupancy; clear flushes everything.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ocup_q   <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ocup_q   <= '0;
        end else begin
            if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_en, pop_en})
                2'b10:   ocup_q <= ocup_q + (AW+1)'(1);
                2'b01:   ocup_q <= ocup_q - (AW+1)'(1);
                default: ocup_q <= ocup_q;
            endcase
        end
    end

endmodule

// File: rtl/pkt_rx_len_tracker.sv
// UDP RX byte-stream pass-through with per-packet length tracking.
// Bytes flow through a registered 2-entry skid buffer; each completed packet
// length is queued for the CSR side. Packets reaching MAX_PKT_BYTES without
// tlast are cut with a forced tlast and the remainder is discarded.
// Optional build macro PKT_RX_LEN_STATS_EN adds packet/drop counters.
module pkt_rx_len_tracker
    import pkt_rx_len_tracker_pkg::*;
#(
    parameter int LEN_SLOTS     = RX_LEN_SLOTS,
    parameter int MAX_PKT_BYTES = INFIFO_KB_SIZE * 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  s_axis_mosi_t                 axis_in_mosi,
    output s_axis_miso_t                 axis_in_miso,
    output s_axis_mosi_t                 axis_out_mosi,
    input  s_axis_miso_t                 axis_out_miso,
    output udp_length_t                  len_o,
    output logic                         len_valid_o,
    input  logic                         len_pop_i,
    output logic [$clog2(LEN_SLOTS):0]   len_ocup_o,
    output logic                         err_oversize_o,
    input  logic                         clear_i
`ifdef PKT_RX_LEN_STATS_EN
    ,
    output logic [31:0]                  pkt_cnt_o,
    output logic [15:0]                  drop_cnt_o
`endif
);

    localparam int CW = $bits(udp_length_t);
    // One extra bit so the limit compare can never wrap.
    localparam logic [CW:0] MAX_CNT = (CW+1)'(MAX_PKT_BYTES);

    fsm_rx_len_t state_q, state_d;
    udp_length_t cnt_q, cnt_d;
    logic        err_q, err_d;
    logic        run_q;

    logic [8:0]  s0_q, s0_d, s1_q, s1_d;     // {tlast, tdata}; s0 is the head
    logic [1:0]  skid_cnt_q, skid_cnt_d, cnt_after_pop;

    logic        len_full, skid_full, in_ready, in_hs, out_pop;
    logic        fwd, fwd_last, len_push, at_max;
    logic [CW:0] cnt_inc;

    assign skid_full = (skid_cnt_q == 2'd2);
    // run_q keeps tready low while reset is held and for the first cycle after.
    assign in_ready  = run_q & ((state_q == DROP_RXL_ST) | (~skid_full & ~len_full));
    assign in_hs     = axis_in_mosi.tvalid & in_ready;
    assign out_pop   = (skid_cnt_q != 2'd0) & axis_out_miso.tready;
    assign cnt_inc   = {1'b0, cnt_q} + (CW+1)'(1);
    assign at_max    = (cnt_inc == MAX_CNT);

    assign axis_in_miso.tready  = in_ready;
    assign axis_out_mosi.tvalid = (skid_cnt_q != 2'd0);
    assign axis_out_mosi.tdata  = s0_q[7:0];
    assign axis_out_mosi.tlast  = s0_q[8];
    assign err_oversize_o       = err_q;

    // Packet FSM next state: counting, truncation and length pushes.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        fwd      = 1'b0;
        fwd_last = 1'b0;
        len_push = 1'b0;
        if (clear_i) begin
            state_d = IDLE_RXL_ST;
            cnt_d   = '0;
            err_d   = 1'b0;
        end else if (in_hs) begin
            case (state_q)
                DROP_RXL_ST: begin
                    if (axis_in_mosi.tlast) begin
                        state_d = IDLE_RXL_ST;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    fwd      = 1'b1;
                    fwd_last = axis_in_mosi.tlast;
                    if (axis_in_mosi.tlast) begin
                        len_push = 1'b1;
                        state_d  = IDLE_RXL_ST;
                        cnt_d    = '0;
                    end else if (at_max) begin
                        len_push = 1'b1;
                        fwd_last = 1'b1;
                        err_d    = 1'b1;
                        state_d  = DROP_RXL_ST;
                        cnt_d    = '0;
                    end else begin
                        state_d  = PKT_RXL_ST;
                        cnt_d    = cnt_inc[CW-1:0];
                    end
                end
            endcase
        end
    end

    // FSM, counter, sticky error and run flag registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE_RXL_ST;
            cnt_q   <= '0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
            run_q   <= 1'b1;
        end
    end

    // Skid buffer next state: pop the head first, then append the new byte.
    always_comb begin
        s0_d          = s0_q;
        s1_d          = s1_q;
        cnt_after_pop = skid_cnt_q;
        if (out_pop) begin
            s0_d          = s1_q;
            cnt_after_pop = skid_cnt_q - 2'd1;
        end
        skid_cnt_d = cnt_after_pop;
        if (fwd) begin
            if (cnt_after_pop == 2'd0) s0_d = {fwd_last, axis_in_mosi.tdata};
            else                       s1_d = {fwd_last, axis_in_mosi.tdata};
            skid_cnt_d = cnt_after_pop + 2'd1;
        end
        if (clear_i) skid_cnt_d = 2'd0;
    end

    // Skid buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_q       <= '0;
            s1_q       <= '0;
            skid_cnt_q <= '0;
        end else begin
            s0_q       <= s0_d;
            s1_q       <= s1_d;
            skid_cnt_q <= skid_cnt_d;
        end
    end

    pkt_rx_len_tracker_eth_fifo #(
        .SLOTS (LEN_SLOTS),
        .WIDTH (CW)
    ) u_len_fifo (
        .clk     (clk),
        .rst     (rst),
        .clear_i (clear_i),
        .push_i  (len_push),
        .din_i   (cnt_inc[CW-1:0]),
        .pop_i   (len_pop_i),
        .dout_o  (len_o),
        .valid_o (len_valid_o),
        .full_o  (len_full),
        .ocup_o  (len_ocup_o)
    );

`ifdef PKT_RX_LEN_STATS_EN
    logic [31:0] pkt_cnt_q;
    logic [15:0] drop_cnt_q;
    logic        enter_drop;

    assign enter_drop = (state_d == DROP_RXL_ST) & (state_q != DROP_RXL_ST);
    assign pkt_cnt_o  = pkt_cnt_q;
    assign drop_cnt_o = drop_cnt_q;

    // Wrapping statistics counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else if (clear_i) begin
            pkt_cnt_q  <= '0;
            drop_cnt_q <= '0;
        end else begin
            if (len_push)   pkt_cnt_q  <= pkt_cnt_q + 32'd1;
            if (enter_drop) drop_cnt_q <= drop_cnt_q + 16'd1;
        end
    end
`endif

endmodule
